// File: rtl/branch_sequencer.sv
// Multi-cycle instruction sequencer: owns PC, IR and flags, steps each
// instruction through FETCH/DEC/EX/WB and resolves branches on stored flags.
module branch_sequencer #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [15:0]     imem_data,
  input  logic [3:0]      flag_in,
  input  logic            flag_we,
  output logic [15:0]     ir,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      flag,
  output logic [2:0]      phase,
  output logic            pc_loaded,
  output logic            halted,
  input  logic            restart
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_FETCH = 3'b001,
    S_DEC   = 3'b010,
    S_EX    = 3'b011,
    S_WB    = 3'b100,
    S_HALT  = 3'b101
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_ir;
  logic [3:0]      r_flag;

  logic [1:0]      w_op1;
  logic [2:0]      w_op2;
  logic [2:0]      w_cond;
  logic [7:0]      w_d;
  logic [3:0]      w_op3;
  logic            w_is_hlt;
  logic            w_cond_true;
  logic            w_taken;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_pc_next;

  assign w_op1 = r_ir[15:14];
  assign w_op2 = r_ir[13:11];
  assign w_cond = r_ir[10:8];
  assign w_d = r_ir[7:0];
  assign w_op3 = r_ir[7:4];
  assign w_is_hlt = (w_op1 == 2'b11) && (w_op3 == 4'b1111);

  // Flags are {S,Z,C,V}; branch conditions use only S, Z and V.
  always_comb begin
    w_cond_true = 1'b0;
    case (w_cond)
      3'b000:  w_cond_true = r_flag[2];
      3'b001:  w_cond_true = r_flag[3] ^ r_flag[0];
      3'b010:  w_cond_true = r_flag[2] | (r_flag[3] ^ r_flag[0]);
      3'b011:  w_cond_true = !r_flag[2];
      default: w_cond_true = 1'b0;
    endcase
    w_taken = 1'b0;
    if (w_op1 == 2'b10) begin
      if (w_op2 == 3'b100)      w_taken = 1'b1;
      else if (w_op2 == 3'b111) w_taken = w_cond_true;
    end
  end

  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_pc_next = w_taken ? (w_pc_inc + {{(PC_W-8){w_d[7]}}, w_d}) : w_pc_inc;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = S_FETCH;
      S_FETCH: if (imem_ready) w_next = S_DEC;
      S_DEC:   w_next = S_EX;
      S_EX:    w_next = S_WB;
      S_WB:    w_next = w_is_hlt ? S_HALT : S_FETCH;
      S_HALT:  if (restart) w_next = S_FETCH;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc   <= RESET_PC;
      r_ir   <= '0;
      r_flag <= '0;
    end else begin
      if (r_state == S_FETCH && imem_ready) r_ir <= imem_data;
      if (r_state == S_EX && flag_we)       r_flag <= flag_in;
      if (r_state == S_WB && !w_is_hlt)     r_pc <= w_pc_next;
      if (r_state == S_HALT && restart)     r_pc <= RESET_PC;
    end
  end

  assign imem_req  = (r_state == S_FETCH);
  assign imem_addr = r_pc;
  assign ir        = r_ir;
  assign pc        = r_pc;
  assign flag      = r_flag;
  assign phase     = r_state;
  assign pc_loaded = (r_state == S_WB) && w_taken;
  assign halted    = (r_state == S_HALT);

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: reset, straight-line timing, branch
// resolution, PC wrap, HALT/restart and mid-fetch reset.
module tb_branch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_data;
  logic [3:0]  flag_in;
  logic        flag_we;
  logic [15:0] ir;
  logic [15:0] pc;
  logic [3:0]  flag;
  logic [2:0]  phase;
  logic        pc_loaded;
  logic        halted;
  logic        restart;

  int tests = 0;
  int fails = 0;
  logic [15:0] model_pc;
  logic [3:0]  model_flag;

  branch_sequencer #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_data(imem_data), .flag_in(flag_in),
    .flag_we(flag_we), .ir(ir), .pc(pc), .flag(flag), .phase(phase),
    .pc_loaded(pc_loaded), .halted(halted), .restart(restart)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction starting at a FETCH negedge; ends at the next FETCH/HALT negedge.
  task automatic exec(input logic [15:0] instr, input int waits, input logic fwe,
                      input logic [3:0] fin, input logic [15:0] exp_pc,
                      input logic exp_ld, input logic exp_halt);
    check("fetch_phase", phase, 3'b001);
    check("fetch_req", imem_req, 1'b1);
    check("fetch_addr", imem_addr, model_pc);
    for (int i = 0; i < waits; i++) begin
      imem_ready = 1'b0; restart = 1'b1; flag_we = 1'b1; flag_in = ~fin;
      @(negedge clk);
      check("wait_phase", phase, 3'b001);
      check("wait_addr", imem_addr, model_pc);
    end
    restart = 1'b0; flag_we = 1'b0; imem_ready = 1'b1; imem_data = instr;
    @(negedge clk);
    check("dec_phase", phase, 3'b010);
    check("dec_ir", ir, instr);
    imem_data = 16'hFFFF; flag_we = 1'b1; flag_in = ~fin;
    @(negedge clk);
    check("ex_phase", phase, 3'b011);
    check("ex_ir_hold", ir, instr);
    check("ex_flag_hold", flag, model_flag);
    imem_ready = 1'b0; flag_we = fwe; flag_in = fin;
    @(negedge clk);
    flag_we = 1'b0;
    if (fwe) model_flag = fin;
    check("wb_phase", phase, 3'b100);
    check("wb_flag", flag, model_flag);
    check("wb_pc_loaded", pc_loaded, exp_ld);
    check("wb_pc_hold", pc, model_pc);
    @(negedge clk);
    check("next_pc", pc, exp_pc);
    check("next_phase", phase, exp_halt ? 3'b101 : 3'b001);
    check("next_halted", halted, exp_halt);
    check("next_pc_loaded", pc_loaded, 1'b0);
    model_pc = exp_pc;
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b1; imem_data = 16'hA0FF; flag_in = 4'hF;
    flag_we = 1'b1; restart = 1'b1;
    model_pc = 16'h0000; model_flag = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_phase", phase, 3'b000);
    check("rst_pc", pc, 16'h0000);
    check("rst_ir", ir, 16'h0000);
    check("rst_flag", flag, 4'h0);
    check("rst_req", imem_req, 1'b0);
    check("rst_loaded", pc_loaded, 1'b0);
    check("rst_halted", halted, 1'b0);
    imem_ready = 1'b0; flag_we = 1'b0; restart = 1'b0;
    rst_n = 1'b1;
    #1 check("idle_after_rst", phase, 3'b000);
    @(negedge clk);
    check("first_fetch_phase", phase, 3'b001);
    check("first_fetch_req", imem_req, 1'b1);
    check("first_fetch_addr", imem_addr, 16'h0000);

    // Straight-line, waits 0/2/0
    exec(16'h0000, 0, 1'b0, 4'h0, 16'h0001, 1'b0, 1'b0);
    exec(16'h1234, 2, 1'b1, 4'b0011, 16'h0002, 1'b0, 1'b0);
    exec(16'h4321, 0, 1'b0, 4'h0, 16'h0003, 1'b0, 1'b0);
    // BR to 0x0010
    exec(16'hA00C, 0, 1'b0, 4'h0, 16'h0010, 1'b1, 1'b0);
    // BE taken with Z written in the same EX, then BNE not taken
    exec(16'hB8FE, 0, 1'b1, 4'b0100, 16'h000F, 1'b1, 1'b0);
    exec(16'hBBFE, 1, 1'b1, 4'b0100, 16'h0010, 1'b0, 1'b0);
    exec(16'hA00F, 0, 1'b0, 4'h0, 16'h0020, 1'b1, 1'b0);
    // Signed less-than taken / not taken
    exec(16'hB905, 0, 1'b1, 4'b1000, 16'h0026, 1'b1, 1'b0);
    exec(16'hA0F9, 0, 1'b0, 4'h0, 16'h0020, 1'b1, 1'b0);
    exec(16'hB905, 0, 1'b1, 4'b1001, 16'h0021, 1'b0, 1'b0);
    // Z|(S^V): not taken on 1001, taken on Z
    exec(16'hBA02, 0, 1'b0, 4'h0, 16'h0022, 1'b0, 1'b0);
    exec(16'hBA02, 0, 1'b1, 4'b0100, 16'h0025, 1'b1, 1'b0);
    // cond 100 never taken; op2 001 never taken
    exec(16'hBC05, 0, 1'b1, 4'b1111, 16'h0026, 1'b0, 1'b0);
    exec(16'h8805, 0, 1'b0, 4'h0, 16'h0027, 1'b0, 1'b0);
    // Unconditional backwards to 0xFFF0, then wrap forward
    exec(16'hA0C8, 0, 1'b0, 4'h0, 16'hFFF0, 1'b1, 1'b0);
    exec(16'hA07F, 0, 1'b0, 4'h0, 16'h0070, 1'b1, 1'b0);
    // HLT
    exec(16'hC0F0, 0, 1'b0, 4'h0, 16'h0070, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      imem_ready = 1'b1; flag_we = 1'b1; flag_in = 4'b0110;
      @(negedge clk);
      check("halt_phase", phase, 3'b101);
      check("halt_halted", halted, 1'b1);
      check("halt_pc", pc, 16'h0070);
      check("halt_req", imem_req, 1'b0);
      check("halt_flag", flag, model_flag);
      check("halt_ir", ir, 16'hC0F0);
    end
    imem_ready = 1'b0; flag_we = 1'b0; restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("restart_phase", phase, 3'b001);
    check("restart_pc", pc, 16'h0000);
    check("restart_addr", imem_addr, 16'h0000);
    check("restart_halted", halted, 1'b0);
    model_pc = 16'h0000;

    exec(16'h0000, 0, 1'b0, 4'h0, 16'h0001, 1'b0, 1'b0);
    // Reset during a FETCH with imem_ready about to be sampled
    imem_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_fetch", phase, 3'b001);
    imem_ready = 1'b1; imem_data = 16'hA00C;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_phase", phase, 3'b000);
    check("midrst_pc", pc, 16'h0000);
    check("midrst_ir", ir, 16'h0000);
    check("midrst_flag", flag, 4'h0);
    check("midrst_req", imem_req, 1'b0);
    @(posedge clk);
    #1;
    check("midrst_hold_phase", phase, 3'b000);
    check("midrst_hold_ir", ir, 16'h0000);
    @(negedge clk);
    imem_ready = 1'b0;
    rst_n = 1'b1;
    #1 check("rel_idle", phase, 3'b000);
    @(negedge clk);
    check("rel_fetch", phase, 3'b001);
    check("rel_addr", imem_addr, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Multi-cycle instruction sequencer for the simple architecture core. It owns the program counter, instruction register and flag register, and steps each instruction through fetch, decode, execute and write-back. It evaluates conditional and unconditional branches against the stored flags to select the next PC. It sits between instruction memory and the datapath, supplying the phase signals that gate register-file and ALU writes.

## Interface
Parameters:
- `PC_W`, 16, width of PC and instruction-memory address
- `RESET_PC`, 16'h0000, PC value after reset and after `restart`

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  instruction fetch request
- `imem_addr`  out  PC_W  fetch address; equals `pc`
- `imem_ready`  in  1  fetch data valid this cycle
- `imem_data`  in  16  instruction word
- `flag_in`  in  4  {S,Z,C,V} from ALU
- `flag_we`  in  1  ALU result updates flags
- `ir`  out  16  current instruction register
- `pc`  out  PC_W  current program counter
- `flag`  out  4  stored {S,Z,C,V}
- `phase`  out  3  000 IDLE, 001 FETCH, 010 DEC, 011 EX, 100 WB, 101 HALT
- `pc_loaded`  out  1  one-cycle pulse in WB when a branch was taken
- `halted`  out  1  high while in HALT
- `restart`  in  1  leave HALT

## Operation
- Decode fields: `op1`=ir[15:14], `op2`=ir[13:11], `cond`=ir[10:8], `d`=ir[7:0]; `op3`=ir[7:4].
- Branch instruction: `op1`==2'b10. HLT: `op1`==2'b11 and `op3`==4'b1111.
- Taken, evaluated in WB on the stored `flag` (not `flag_in`):
  - `op2`==3'b100: always taken.
  - `op2`==3'b111 with `cond`: 000 Z; 001 S^V; 010 Z|(S^V); 011 !Z; 100–111 not taken.
  - Any other `op2`: not taken.
- Next PC: taken → pc+1+sext(d); else pc+1. Arithmetic is modulo 2^PC_W, and wrap-around is silent.
- FSM:
  - IDLE → FETCH unconditionally.
  - FETCH: `imem_req`=1 and holds; on `imem_ready` latch `ir`<=`imem_data`, then → DEC.
  - DEC → EX.
  - EX: if `flag_we`, `flag`<=`flag_in`. Then → WB.
  - WB: if HLT → HALT with `pc` unchanged. Otherwise update `pc`, then → FETCH.
  - HALT: hold all state. On `restart`, `pc`<=RESET_PC, then → FETCH.
- `flag_we` outside EX is ignored. `imem_ready` outside FETCH is ignored. `restart` outside HALT is ignored.
- Branch instructions do not modify flags, because the datapath never asserts `flag_we` for them. If `flag_we` is asserted anyway, the EX update still applies before the WB evaluation.

## Timing
- Reset (async, `rst_n`=0): phase=IDLE, `pc`=RESET_PC, `ir`=0, `flag`=0, `imem_req`=0, `pc_loaded`=0, `halted`=0. Takes effect immediately in any state, including mid-fetch. A pending fetch is abandoned.
- First `imem_req` is in the second rising edge after `rst_n` deasserts: the IDLE cycle comes first.
- `imem_req` and `halted` are Moore outputs decoded from state. `imem_addr` is stable for the whole FETCH.
- Minimum 4 cycles per instruction (FETCH with `imem_ready` in its first cycle, DEC, EX, WB). Each wait cycle in FETCH adds 1.
- `pc` changes on the edge leaving WB. The new value is visible in the following FETCH.
- `pc_loaded` is high exactly during the WB cycle of a taken branch. It is combinational from `ir` and `flag`.
- `restart` sampled in HALT: the next cycle is FETCH at RESET_PC.

## Test plan
- Reset: hold `rst_n`=0 and check all outputs at reset values. Release; cycle 1 phase=IDLE, cycle 2 phase=FETCH with `imem_req`=1 and `imem_addr`=0.
- Straight-line: three non-branch instructions with `imem_ready` delayed 0, 2 and 0 cycles → `pc` 0→1→2→3, instruction lengths 4, 6 and 4 cycles, `pc_loaded` never high.
- Conditional taken and not taken:
  - EX with `flag_we`=1, `flag_in`=4'b0100 (Z), then at pc=0x0010 ir=0xB8FE (BE, d=-2) → `pc`=0x000F, `pc_loaded`=1.
  - Same setup with ir=0xBBFE (BNE) → `pc`=0x0011, `pc_loaded`=0.
- Signed-less-than: `flag`=4'b1000 (S=1, V=0), ir=0xB905 at pc=0x0020 → `pc`=0x0026. With `flag`=4'b1001 → `pc`=0x0021.
- Unconditional with wrap: pc=0xFFF0, ir=0xA07F → `pc`=0x0070.
- HLT/restart and reset:
  - ir=0xC0F0 → phase=HALT and `halted`=1, `pc` held for 10 cycles. Pulse `restart` → FETCH at 0x0000.
  - Separately, drop `rst_n` mid-FETCH with `imem_ready` pending → immediate IDLE with reset values.
